zbt_port_arbiter: RTL and testbench

Shares the single pipelined ZBT SRAM port between three requesters: the VGA display fetch, the NTSC capture writer, and a processing (filter) read/write port. The block sits between `ntsc_to_zbt`, the display reader, and the top-level ZBT pins. It buffers bursty NTSC writes in a small FIFO and gives the display strict priority. It tracks in-flight reads so returned data reaches the correct requester after the fixed ZBT latency.

---
 rtl/zbt_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_zbt_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_port_arbiter.sv
// Shares one pipelined ZBT SRAM port between display reads, FIFO-buffered NTSC
// writes and a processing read/write port; a tag pipeline routes returning data.
package zbt_port_arbiter_pkg;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 36;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_PROC = 2'd2
  } owner_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef struct packed {
    owner_e            owner;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } tag_t;
endpackage

module zbt_port_arbiter
  import zbt_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 2,
  parameter int unsigned ZBT_LAT    = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              ntsc_we,
  input  logic [ADDR_W-1:0] ntsc_addr,
  input  logic [DATA_W-1:0] ntsc_data,
  output logic              ntsc_full,
  output logic              ntsc_ovf,
  output logic [7:0]        ovf_cnt,
  input  logic              proc_req,
  input  logic              proc_we,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [DATA_W-1:0] proc_wdata,
  output logic              proc_gnt,
  output logic [DATA_W-1:0] proc_rdata,
  output logic              proc_rvalid,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic              zbt_we,
  output logic [DATA_W-1:0] zbt_wdata,
  output logic              zbt_wdata_oe,
  input  logic [DATA_W-1:0] zbt_rdata
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned OVF_W  = 8;
  localparam int unsigned STAGES = ZBT_LAT + 1;

  wr_entry_t          fifo_mem [DEPTH];
  wr_entry_t          fifo_head;
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic [CNT_W-1:0]   fifo_cnt_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  tag_t [STAGES-1:0]  pipe;

  logic              fifo_empty;
  logic              fifo_at_cap;
  logic              starved;
  logic              proc_win;
  logic              pop;
  logic              push;
  logic              drop;
  logic [ADDR_W-1:0] issue_addr;
  tag_t              issue_tag;

  assign fifo_head = fifo_mem[rd_ptr];

  // Slot arbitration: display, starved proc, NTSC FIFO, then proc.
  always_comb begin
    fifo_empty   = (fifo_cnt == '0);
    fifo_at_cap  = (fifo_cnt == CNT_W'(DEPTH));
    starved      = (32'(wait_cnt) >= STARVE_MAX);
    proc_win     = !disp_req && proc_req && (starved || fifo_empty);
    pop          = !disp_req && !proc_win && !fifo_empty;
    push         = ntsc_we && (!fifo_at_cap || pop);
    drop         = ntsc_we && fifo_at_cap && !pop;
    fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  end

  // Winner's address and tag; with no winner the pins keep the last address.
  always_comb begin
    issue_addr = zbt_addr;
    issue_tag  = '{owner: OWN_NONE, we: 1'b0, wdata: '0};
    if (disp_req) begin
      issue_addr      = disp_addr;
      issue_tag.owner = OWN_DISP;
    end else if (proc_win) begin
      issue_addr      = proc_addr;
      issue_tag.owner = OWN_PROC;
      issue_tag.we    = proc_we;
      issue_tag.wdata = proc_we ? proc_wdata : '0;
    end else if (pop) begin
      issue_addr      = fifo_head.addr;
      issue_tag.we    = 1'b1;
      issue_tag.wdata = fifo_head.data;
    end
  end

  assign proc_gnt = proc_win && !rst;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{addr: ntsc_addr, data: ntsc_data};
    end
  end

  // FIFO bookkeeping, overflow accounting and proc wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      ntsc_full <= 1'b0;
      ntsc_ovf  <= 1'b0;
      ovf_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      fifo_cnt  <= fifo_cnt_nxt;
      ntsc_full <= (fifo_cnt_nxt == CNT_W'(DEPTH));
      if (drop) begin
        ntsc_ovf <= 1'b1;
        if (ovf_cnt != '1) begin
          ovf_cnt <= ovf_cnt + OVF_W'(1);
        end
      end
      if (!proc_req || proc_win) begin
        wait_cnt <= '0;
      end else if (wait_cnt != '1) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Issue register, tag pipeline and read-data return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zbt_addr    <= '0;
      pipe        <= '0;
      disp_rdata  <= '0;
      disp_rvalid <= 1'b0;
      proc_rdata  <= '0;
      proc_rvalid <= 1'b0;
    end else begin
      zbt_addr    <= issue_addr;
      pipe        <= {pipe[STAGES-2:0], issue_tag};
      disp_rvalid <= 1'b0;
      proc_rvalid <= 1'b0;
      if (!pipe[ZBT_LAT].we && pipe[ZBT_LAT].owner == OWN_DISP) begin
        disp_rdata  <= zbt_rdata;
        disp_rvalid <= 1'b1;
      end
      if (!pipe[ZBT_LAT].we && pipe[ZBT_LAT].owner == OWN_PROC) begin
        proc_rdata  <= zbt_rdata;
        proc_rvalid <= 1'b1;
      end
    end
  end

  assign zbt_we       = pipe[0].we;
  assign zbt_wdata_oe = pipe[ZBT_LAT].we;
  assign zbt_wdata    = pipe[ZBT_LAT].wdata;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Directed bench for zbt_port_arbiter: a cycle-level reference model plus a
// ZBT SRAM stand-in that returns a fixed pattern derived from the pin address.
`timescale 1ns/1ps
module tb_zbt_port_arbiter;
  localparam int L      = 2;
  localparam int RING   = 8;
  localparam int STARVE = 8;
  localparam int DEPTH  = 4;
  localparam int W_NONE = 0;
  localparam int W_DISP = 1;
  localparam int W_PROC = 2;
  localparam int W_NTSC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [18:0] disp_addr = '0;
  logic        ntsc_we = 1'b0;
  logic [18:0] ntsc_addr = '0;
  logic [35:0] ntsc_data = '0;
  logic        proc_req = 1'b0;
  logic        proc_we = 1'b0;
  logic [18:0] proc_addr = '0;
  logic [35:0] proc_wdata = '0;
  logic [35:0] zbt_rdata = '0;

  logic [35:0] disp_rdata;
  logic        disp_rvalid;
  logic        ntsc_full;
  logic        ntsc_ovf;
  logic [7:0]  ovf_cnt;
  logic        proc_gnt;
  logic [35:0] proc_rdata;
  logic        proc_rvalid;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_wdata;
  logic        zbt_wdata_oe;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dv_seen = 0;

  zbt_port_arbiter #(.FIFO_AW(2), .ZBT_LAT(L), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .ntsc_we(ntsc_we), .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data),
    .ntsc_full(ntsc_full), .ntsc_ovf(ntsc_ovf), .ovf_cnt(ovf_cnt),
    .proc_req(proc_req), .proc_we(proc_we), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_gnt(proc_gnt),
    .proc_rdata(proc_rdata), .proc_rvalid(proc_rvalid),
    .zbt_addr(zbt_addr), .zbt_we(zbt_we), .zbt_wdata(zbt_wdata),
    .zbt_wdata_oe(zbt_wdata_oe), .zbt_rdata(zbt_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [35:0] rd_pat(input logic [18:0] a);
    return {a[16:0], a} ^ 36'h9A5C30F1E;
  endfunction

  // Reference model state: FIFO as a queue, outputs scheduled by cycle.
  typedef struct packed {
    logic [18:0] a;
    logic [35:0] d;
  } wr_t;

  wr_t         mq[$];
  wr_t         hd;
  int          m_wait = 0;
  bit          m_ovf = 1'b0;
  int          m_ovf_cnt = 0;
  bit          m_full = 1'b0;
  int          mcyc = 0;
  int          k;
  int          win;
  bit          was_full;
  logic        s_we [RING];
  logic        s_av [RING];
  logic [18:0] s_addr [RING];
  logic        s_oe [RING];
  logic [35:0] s_wd [RING];
  logic        s_dv [RING];
  logic [35:0] s_dd [RING];
  logic        s_pv [RING];
  logic [35:0] s_pd [RING];
  logic [18:0] e_zaddr = '0;
  logic [35:0] e_drd = '0;
  logic [35:0] e_prd = '0;
  logic [18:0] hz [L+1];

  task automatic sched_issue(input int c, input logic we, input logic [18:0] a, input logic [35:0] d);
    s_av[(c+1)%RING] = 1'b1;
    s_we[(c+1)%RING] = we;
    s_addr[(c+1)%RING] = a;
    if (we) begin
      s_oe[(c+1+L)%RING] = 1'b1;
      s_wd[(c+1+L)%RING] = d;
    end
  endtask

  always @(negedge clk) begin
    if (disp_rvalid) n_dv_seen++;
    if (rst) begin
      mq.delete();
      m_wait = 0; m_ovf = 1'b0; m_ovf_cnt = 0; m_full = 1'b0; mcyc = 0;
      e_zaddr = '0; e_drd = '0; e_prd = '0;
      for (int i = 0; i < RING; i++) begin
        s_we[i] = 1'b0; s_av[i] = 1'b0; s_addr[i] = '0; s_oe[i] = 1'b0; s_wd[i] = '0;
        s_dv[i] = 1'b0; s_dd[i] = '0; s_pv[i] = 1'b0; s_pd[i] = '0;
      end
      chk("rst_zbt_we", zbt_we, 0);
      chk("rst_zbt_addr", zbt_addr, 0);
      chk("rst_zbt_wdata", zbt_wdata, 0);
      chk("rst_zbt_oe", zbt_wdata_oe, 0);
      chk("rst_disp_rvalid", disp_rvalid, 0);
      chk("rst_disp_rdata", disp_rdata, 0);
      chk("rst_proc_rvalid", proc_rvalid, 0);
      chk("rst_proc_rdata", proc_rdata, 0);
      chk("rst_ntsc_full", ntsc_full, 0);
      chk("rst_ntsc_ovf", ntsc_ovf, 0);
      chk("rst_ovf_cnt", ovf_cnt, 0);
      chk("rst_proc_gnt", proc_gnt, 0);
    end else begin
      k = mcyc % RING;
      if (s_av[k]) e_zaddr = s_addr[k];
      if (s_dv[k]) e_drd = s_dd[k];
      if (s_pv[k]) e_prd = s_pd[k];
      if (disp_req) win = W_DISP;
      else if (proc_req && m_wait >= STARVE) win = W_PROC;
      else if (mq.size() != 0) win = W_NTSC;
      else if (proc_req) win = W_PROC;
      else win = W_NONE;
      chk("zbt_we", zbt_we, s_we[k]);
      chk("zbt_addr", zbt_addr, e_zaddr);
      chk("zbt_wdata_oe", zbt_wdata_oe, s_oe[k]);
      if (s_oe[k]) chk("zbt_wdata", zbt_wdata, s_wd[k]);
      chk("disp_rvalid", disp_rvalid, s_dv[k]);
      chk("disp_rdata", disp_rdata, e_drd);
      chk("proc_rvalid", proc_rvalid, s_pv[k]);
      chk("proc_rdata", proc_rdata, e_prd);
      chk("ntsc_full", ntsc_full, m_full);
      chk("ntsc_ovf", ntsc_ovf, m_ovf);
      chk("ovf_cnt", ovf_cnt, m_ovf_cnt);
      chk("proc_gnt", proc_gnt, win == W_PROC);
      s_we[k] = 1'b0; s_av[k] = 1'b0; s_oe[k] = 1'b0; s_dv[k] = 1'b0; s_pv[k] = 1'b0;
      was_full = (mq.size() == DEPTH);
      case (win)
        W_DISP: begin
          sched_issue(mcyc, 1'b0, disp_addr, '0);
          s_dv[(mcyc+2+L)%RING] = 1'b1;
          s_dd[(mcyc+2+L)%RING] = rd_pat(disp_addr);
        end
        W_PROC: begin
          sched_issue(mcyc, proc_we, proc_addr, proc_wdata);
          if (!proc_we) begin
            s_pv[(mcyc+2+L)%RING] = 1'b1;
            s_pd[(mcyc+2+L)%RING] = rd_pat(proc_addr);
          end
        end
        W_NTSC: begin
          hd = mq.pop_front();
          sched_issue(mcyc, 1'b1, hd.a, hd.d);
        end
        default: ;
      endcase
      if (ntsc_we) begin
        if (!was_full || win == W_NTSC) mq.push_back('{a: ntsc_addr, d: ntsc_data});
        else begin
          m_ovf = 1'b1;
          if (m_ovf_cnt < 255) m_ovf_cnt++;
        end
      end
      m_full = (mq.size() == DEPTH);
      if (!proc_req || win == W_PROC) m_wait = 0;
      else if (m_wait < 15) m_wait++;
      mcyc++;
    end
    // ZBT stand-in: read data for the address presented L cycles earlier.
    for (int i = L; i > 0; i--) hz[i] = hz[i-1];
    hz[0] = zbt_addr;
    zbt_rdata = rd_pat(hz[L]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    for (int i = 0; i <= L; i++) hz[i] = '0;
    repeat (3) step();
    #1;
    chk("reset_zbt_addr", zbt_addr, 0);
    chk("reset_ovf_cnt", ovf_cnt, 0);
    step(); rst = 1'b0;
    step(); step(); #1;
    chk("idle_zbt_we", zbt_we, 0);
    chk("idle_disp_rvalid", disp_rvalid, 0);

    // Single NTSC write: pins at +2, data at +4.
    step(); ntsc_we = 1'b1; ntsc_addr = 19'h00123; ntsc_data = 36'hABCDE1234;
    step(); ntsc_we = 1'b0;
    step(); #1;
    chk("t1_zbt_we", zbt_we, 1);
    chk("t1_zbt_addr", zbt_addr, 19'h00123);
    step();
    step(); #1;
    chk("t1_oe", zbt_wdata_oe, 1);
    chk("t1_wdata", zbt_wdata, 36'hABCDE1234);
    chk("t1_ovf_cnt", ovf_cnt, 0);

    // Processing write on an idle port.
    step(); proc_req = 1'b1; proc_we = 1'b1; proc_addr = 19'h05555; proc_wdata = 36'hC0FFEE123;
    #1; chk("pw_gnt", proc_gnt, 1);
    step(); proc_req = 1'b0; proc_we = 1'b0; #1;
    chk("pw_zbt_we", zbt_we, 1);
    chk("pw_zbt_addr", zbt_addr, 19'h05555);
    step(); step(); #1;
    chk("pw_oe", zbt_wdata_oe, 1);
    chk("pw_wdata", zbt_wdata, 36'hC0FFEE123);
    repeat (4) step();

    // Display priority with NTSC words queued behind it.
    n0 = n_dv_seen;
    for (int i = 0; i < 20; i++) begin
      step();
      disp_req = 1'b1; disp_addr = 19'(i);
      ntsc_we = (i == 2 || i == 5 || i == 8);
      ntsc_addr = 19'h100 + 19'(i / 3);
      ntsc_data = 36'h100000000 + 36'(i);
    end
    step(); disp_req = 1'b0; ntsc_we = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step(); #1;
      chk("prio_zbt_we", zbt_we, 1);
      chk("prio_zbt_addr", zbt_addr, 19'h100 + 19'(j - 1));
    end
    repeat (6) step();
    chk("prio_disp_strobes", 64'(n_dv_seen - n0), 20);

    // Overflow: six pushes while the display owns every slot.
    for (int i = 0; i < 8; i++) begin
      step();
      disp_req = 1'b1; disp_addr = 19'h200 + 19'(i);
      ntsc_we = (i < 6);
      ntsc_addr = 19'h300 + 19'(i);
      ntsc_data = 36'h300000000 + 36'(i);
      if (i == 7) begin
        #1;
        chk("ovf_full", ntsc_full, 1);
        chk("ovf_flag", ntsc_ovf, 1);
        chk("ovf_cnt2", ovf_cnt, 2);
      end
    end
    step(); disp_req = 1'b0; ntsc_we = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step(); #1;
      chk("ovf_drain_we", zbt_we, j <= 4);
      if (j <= 4) chk("ovf_drain_addr", zbt_addr, 19'h300 + 19'(j - 1));
    end
    repeat (4) step();

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 4; i++) begin
      step();
      disp_req = 1'b1; disp_addr = 19'h210 + 19'(i);
      ntsc_we = 1'b1; ntsc_addr = 19'h500 + 19'(i); ntsc_data = 36'h500000000 + 36'(i);
    end
    step(); disp_req = 1'b0; ntsc_we = 1'b1; ntsc_addr = 19'h504; ntsc_data = 36'h500000004;
    #1; chk("pp_full_before", ntsc_full, 1);
    step(); ntsc_we = 1'b0; #1;
    chk("pp_full_after", ntsc_full, 1);
    chk("pp_ovf_cnt", ovf_cnt, 2);
    chk("pp_zbt_addr0", zbt_addr, 19'h500);
    for (int j = 2; j <= 5; j++) begin
      step(); #1;
      chk("pp_zbt_we", zbt_we, 1);
      chk("pp_zbt_addr", zbt_addr, 19'h500 + 19'(j - 1));
    end
    repeat (6) step();

    // Starvation: FIFO kept non-empty, proc read wins once its wait reaches 8.
    step(); ntsc_we = 1'b1; ntsc_addr = 19'h600; ntsc_data = 36'h600000000;
    for (int i = 0; i <= 8; i++) begin
      step();
      proc_req = 1'b1; proc_we = 1'b0; proc_addr = 19'h40000;
      ntsc_we = (i < 8);
      ntsc_addr = 19'h601 + 19'(i);
      ntsc_data = 36'h600000001 + 36'(i);
      #1; chk("starve_gnt", proc_gnt, i == 8);
    end
    for (int j = 9; j <= 12; j++) begin
      step();
      if (j == 9) begin
        proc_req = 1'b0; ntsc_we = 1'b0;
      end
      #1; chk("starve_rvalid", proc_rvalid, j == 12);
      if (j == 12) chk("starve_rdata", proc_rdata, 36'h9A5C70F1E);
    end
    repeat (6) step();

    // Reset while a display read is in flight.
    step(); disp_req = 1'b1; disp_addr = 19'h07ABC;
    step(); disp_req = 1'b0;
    step(); rst = 1'b1; n0 = n_dv_seen;
    step(); #1;
    chk("mid_rst_ovf_cnt", ovf_cnt, 0);
    chk("mid_rst_ovf", ntsc_ovf, 0);
    step(); rst = 1'b0;
    repeat (6) step();
    chk("mid_rst_no_rvalid", 64'(n_dv_seen - n0), 0);
    step(); disp_req = 1'b1; disp_addr = 19'h12345;
    step(); disp_req = 1'b0;
    step();
    step(); #1; chk("post_rst_early", disp_rvalid, 0);
    step(); #1;
    chk("post_rst_rvalid", disp_rvalid, 1);
    chk("post_rst_rdata", disp_rdata, 36'h0BFEA2C5B);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
